imm_extend_stage: RTL and testbench

Registered successor to the combinational immediate extender in the decode stage. It accepts 16-bit instructions over a valid/ready handshake and produces the extended immediate generalised to DATA_W bits. It also computes the PC-relative branch/jump target. Results are buffered in a DEPTH-entry output queue and can be flushed when the pipeline redirects.

---
 rtl/isa_pkg.sv | 19 +
 rtl/imm_ext_core.sv | 27 ++
 rtl/imm_extend_stage.sv | 63 ++++++
 tb/tb_imm_extend_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: opcodes, extension-kind encoding and PC increment shared by the immediate extend stage
package isa_pkg;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_BLTZ  = 5'b01110;
  localparam logic [4:0] OP_BGEZ  = 5'b01111;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  typedef enum logic [2:0] {K_S5 = 3'd0, K_Z5 = 3'd1, K_S8 = 3'd2, K_Z8 = 3'd3, K_S11 = 3'd4} kind_e;
  localparam int PC_INC = 2;
endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational instr -> {imm, kind, tgt_valid}; ports instr (16b), imm (DATA_W), kind (3b), tgt_valid
module imm_ext_core import isa_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        kind,
  output logic              tgt_valid
);
  logic [4:0] op;
  kind_e k;
  assign op = instr[15:11];
  always_comb begin
    k = (op inside {OP_J, OP_JAL}) ? K_S11 :
        (op inside {OP_ADDI, OP_SUBI}) ? K_S5 :
        (op inside {OP_XORI, OP_ANDNI}) ? K_Z5 :
        (op inside {OP_LBI, OP_JR, OP_JALR, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ}) ? K_S8 :
        (op == OP_SLBI) ? K_Z8 : K_S5;
    imm = (k == K_S11) ? {{(DATA_W-11){instr[10]}}, instr[10:0]} :
          (k == K_S8)  ? {{(DATA_W-8){instr[7]}}, instr[7:0]} :
          (k == K_Z8)  ? DATA_W'(instr[7:0]) :
          (k == K_Z5)  ? DATA_W'(instr[4:0]) :
                         {{(DATA_W-5){instr[4]}}, instr[4:0]};
    tgt_valid = op inside {OP_J, OP_JAL, OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ};
  end
  assign kind = k;
endmodule

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extender + PC-relative target with a DEPTH-entry output FIFO; in_* valid/ready in, out_* valid/ready out, flush, async active-low rst_n
module imm_extend_stage import isa_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_kind,
  output logic [DATA_W-1:0] out_target,
  output logic              out_tgt_valid
);
  localparam int EW = 2*DATA_W + 4;
  if (DEPTH < 1 || DEPTH > 2 || DATA_W < 16) begin : g_bad_param
    $error("imm_extend_stage: DEPTH must be 1 or 2 and DATA_W at least 16");
  end
  logic [DATA_W-1:0] imm, tgt;
  logic [2:0] kind;
  logic tv, push, pop, wr_q, wr_d, rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;
  logic [EW-1:0] mem_q [2];
  imm_ext_core #(.DATA_W(DATA_W)) u_core (
    .instr(in_instr),
    .imm(imm),
    .kind(kind),
    .tgt_valid(tv)
  );
  assign tgt = tv ? in_pc + DATA_W'(PC_INC) + imm : '0;
  // With a single entry the pointers never leave slot 0
  function automatic logic nxt(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction
  assign in_ready  = cnt_q < 2'(DEPTH);
  assign out_valid = cnt_q != 2'd0;
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign {out_tgt_valid, out_kind, out_target, out_imm} = mem_q[rd_q];
  always_comb begin
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    wr_d  = flush ? 1'b0 : push ? nxt(wr_q) : wr_q;
    rd_d  = flush ? 1'b0 : pop ? nxt(rd_q) : rd_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      if (push && !flush) mem_q[wr_q] <= {tv, kind, tgt, imm};
    end
  end
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: table vectors, directed corner sequences and random traffic against a queue model
module tb_imm_extend_stage;
  logic clk = 0, rst_n, in_valid, in_ready, in_ready32, flush, out_ready;
  logic [15:0] in_instr, in_pc, o_imm, o_tgt;
  logic [31:0] pc32, o_imm32, o_tgt32;
  logic [2:0] o_kind, o_kind32;
  logic o_valid, o_tv, o_valid32, o_tv32;
  int checks = 0, errors = 0;
  assign pc32 = {16'h0, in_pc};
  always #5 clk = ~clk;
  imm_extend_stage #(.DATA_W(16), .DEPTH(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(o_valid), .out_ready(out_ready), .out_imm(o_imm),
    .out_kind(o_kind), .out_target(o_tgt), .out_tgt_valid(o_tv)
  );
  imm_extend_stage #(.DATA_W(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .in_pc(pc32), .flush(flush), .out_valid(o_valid32), .out_ready(out_ready), .out_imm(o_imm32),
    .out_kind(o_kind32), .out_target(o_tgt32), .out_tgt_valid(o_tv32)
  );
  typedef struct {
    logic [31:0] imm16, tgt16, imm32, tgt32;
    logic [2:0] kind;
    logic tv;
  } exp_t;
  typedef struct {
    logic [15:0] ins, pc, imm16, tgt16;
    logic [31:0] imm32, tgt32;
    logic [2:0] kind;
    logic tv;
  } vec_t;
  exp_t mq[$];
  vec_t tab[11];
  logic [4:0] ops[16] = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                          5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10010, 5'b11000, 5'b10100, 5'b00000};
  function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    int op, k, n;
    bit sgn;
    longint f, v, t;
    op = int'(ins[15:11]);
    case (op)
      4, 6: k = 4;
      10, 11: k = 1;
      5, 7, 12, 13, 14, 15, 24: k = 2;
      18: k = 3;
      default: k = 0;
    endcase
    n = (k == 4) ? 11 : (k == 2 || k == 3) ? 8 : 5;
    sgn = (k == 0 || k == 2 || k == 4);
    f = longint'(ins) & ((64'sd1 << n) - 1);
    v = (sgn && f >= (64'sd1 << (n - 1))) ? f - (64'sd1 << n) : f;
    e.tv = op inside {4, 6, 12, 13, 14, 15};
    t = longint'(pc) + 2 + v;
    e.kind = 3'(k);
    e.imm16 = 32'(v & 64'hFFFF);
    e.imm32 = 32'(v & 64'hFFFF_FFFF);
    e.tgt16 = e.tv ? 32'(t & 64'hFFFF) : 32'd0;
    e.tgt32 = e.tv ? 32'(t & 64'hFFFF_FFFF) : 32'd0;
    return e;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic check_outputs(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
    chk({tag, " in_ready32"}, 32'(in_ready32), 32'(mq.size() < 2));
    chk({tag, " out_valid"}, 32'(o_valid), 32'(mq.size() != 0));
    chk({tag, " out_valid32"}, 32'(o_valid32), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({tag, " imm16"}, 32'(o_imm), mq[0].imm16);
      chk({tag, " tgt16"}, 32'(o_tgt), mq[0].tgt16);
      chk({tag, " kind16"}, 32'(o_kind), 32'(mq[0].kind));
      chk({tag, " tv16"}, 32'(o_tv), 32'(mq[0].tv));
      chk({tag, " imm32"}, o_imm32, mq[0].imm32);
      chk({tag, " tgt32"}, o_tgt32, mq[0].tgt32);
      chk({tag, " kind32"}, 32'(o_kind32), 32'(mq[0].kind));
      chk({tag, " tv32"}, 32'(o_tv32), 32'(mq[0].tv));
    end
  endtask
  task automatic cyc(input string tag, input logic v, input logic [15:0] ins, input logic [15:0] pc,
                     input logic ordy, input logic fl);
    bit push_m, pop_m;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    push_m = v && (mq.size() < 2);
    pop_m = ordy && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(model(ins, pc));
    end
    check_outputs(tag);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(o_valid), 0);
    chk({tag, " valid32"}, 32'(o_valid32), 0);
    chk({tag, " imm"}, 32'(o_imm), 0);
    chk({tag, " target"}, 32'(o_tgt), 0);
    chk({tag, " kind"}, 32'(o_kind), 0);
    chk({tag, " tgt_valid"}, 32'(o_tv), 0);
    chk({tag, " imm32"}, o_imm32, 0);
  endtask
  initial begin
    tab[0]  = '{16'h401F, 16'h0000, 16'hFFFF, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b0};
    tab[1]  = '{16'h501F, 16'h0000, 16'h001F, 16'h0000, 32'h0000001F, 32'h00000000, 3'd1, 1'b0};
    tab[2]  = '{16'h9080, 16'h0000, 16'h0080, 16'h0000, 32'h00000080, 32'h00000000, 3'd3, 1'b0};
    tab[3]  = '{16'hC080, 16'h0000, 16'hFF80, 16'h0000, 32'hFFFFFF80, 32'h00000000, 3'd2, 1'b0};
    tab[4]  = '{16'h2400, 16'h1000, 16'hFC00, 16'h0C02, 32'hFFFFFC00, 32'h00000C02, 3'd4, 1'b1};
    tab[5]  = '{16'h60FE, 16'h0010, 16'hFFFE, 16'h0010, 32'hFFFFFFFE, 32'h00000010, 3'd2, 1'b1};
    tab[6]  = '{16'h2880, 16'h1234, 16'hFF80, 16'h0000, 32'hFFFFFF80, 32'h00000000, 3'd2, 1'b0};
    tab[7]  = '{16'h6802, 16'hFFFE, 16'h0002, 16'h0002, 32'h00000002, 32'h00010002, 3'd2, 1'b1};
    tab[8]  = '{16'h3000, 16'h0100, 16'h0000, 16'h0102, 32'h00000000, 32'h00000102, 3'd4, 1'b1};
    tab[9]  = '{16'h5810, 16'h0000, 16'h0010, 16'h0000, 32'h00000010, 32'h00000000, 3'd1, 1'b0};
    tab[10] = '{16'hA01F, 16'h0000, 16'hFFFF, 16'h0000, 32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b0};
    rst_n = 0; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst_n = 1;
    #1;
    chk("reset in_ready", 32'(in_ready), 1);
    // back-to-back with out_ready=1: each result appears the cycle after its push
    for (int i = 0; i < 11; i++) begin
      cyc("tab", 1, tab[i].ins, tab[i].pc, 1, 0);
      chk($sformatf("tab%0d valid", i), 32'(o_valid), 1);
      chk($sformatf("tab%0d imm16", i), 32'(o_imm), 32'(tab[i].imm16));
      chk($sformatf("tab%0d tgt16", i), 32'(o_tgt), 32'(tab[i].tgt16));
      chk($sformatf("tab%0d kind", i), 32'(o_kind), 32'(tab[i].kind));
      chk($sformatf("tab%0d tv", i), 32'(o_tv), 32'(tab[i].tv));
      chk($sformatf("tab%0d imm32", i), o_imm32, tab[i].imm32);
      chk($sformatf("tab%0d tgt32", i), o_tgt32, tab[i].tgt32);
    end
    cyc("drain", 0, 0, 0, 1, 0);
    // backpressure: third push refused, head held
    cyc("bp1", 1, tab[4].ins, tab[4].pc, 0, 0);
    cyc("bp2", 1, tab[5].ins, tab[5].pc, 0, 0);
    chk("bp full in_ready", 32'(in_ready), 0);
    cyc("bp3", 1, tab[6].ins, tab[6].pc, 0, 0);
    chk("bp hold imm", 32'(o_imm), 32'(tab[4].imm16));
    chk("bp hold tgt", 32'(o_tgt), 32'(tab[4].tgt16));
    cyc("bp pop1", 0, 0, 0, 1, 0);
    chk("bp after pop in_ready", 32'(in_ready), 1);
    chk("bp second head", 32'(o_imm), 32'(tab[5].imm16));
    cyc("bp pop2", 0, 0, 0, 1, 0);
    chk("bp empty", 32'(o_valid), 0);
    // flush with full queue and with an acceptable incoming entry
    cyc("fl1", 1, tab[1].ins, 0, 0, 0);
    cyc("fl2", 1, tab[2].ins, 0, 0, 0);
    cyc("fl full", 1, tab[3].ins, 0, 1, 1);
    chk("flush full valid", 32'(o_valid), 0);
    cyc("fl3", 1, tab[7].ins, tab[7].pc, 0, 0);
    cyc("fl push", 1, tab[8].ins, tab[8].pc, 0, 1);
    chk("flush drop valid", 32'(o_valid), 0);
    cyc("fl idle", 0, 0, 0, 1, 0);
    // asynchronous reset between edges
    cyc("ar push", 1, tab[4].ins, tab[4].pc, 0, 0);
    chk("ar before valid", 32'(o_valid), 1);
    #2 rst_n = 0;
    #1;
    chk_zero("async reset");
    mq.delete();
    #2 rst_n = 1;
    for (int i = 0; i < 400; i++)
      cyc("rand", $urandom_range(0, 3) != 0, {ops[$urandom_range(0, 15)], 11'($urandom)}, 16'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
